// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants, FSM encoding and queue entry layout for the instruction fetch unit.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0000
`endif
`ifndef SRAM_ADDR_W
`define SRAM_ADDR_W 20
`endif

package inst_fetch_unit_pkg;

  localparam int unsigned SRAM_ADDR_W = `SRAM_ADDR_W;
  localparam logic [31:0] INST_NOP    = `INST_NOP;
  localparam int unsigned ENTRY_W     = 65;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Queue entry, MSB first: {fault, pc, inst}.
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch queue: DEPTH entries with wrap-bit pointers. Flush overrides push/pop;
// flush together with load restarts the queue holding only wdata_i.
module inst_fetch_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty_o = (rd_ptr_q == wr_ptr_q);
  assign full_o  = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) &&
                   (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]);
  assign head_o  = mem[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_en    = 1'b0;
    wr_idx   = wr_ptr_q[PTR_W-1:0];
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = load_i ? PTR_ONE : '0;
      wr_en    = load_i;
      wr_idx   = '0;
    end else begin
      if (pop_i && !empty_o) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // When full, a same-cycle pop frees the slot being overwritten.
      if (push_i && (!full_o || pop_i)) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= '0;
      end else if (wr_en && (wr_idx == PTR_W'(gi))) begin
        entry_q <= wdata_i;
      end
    end

    assign mem[gi] = entry_q;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, fetch FSM and prefetch queue toward decode.
// Define IFETCH_ALIGN_CHECK_EN to turn misaligned redirects into a faulting queue entry.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sram_grant_i,
  output logic [SRAM_ADDR_W-1:0] ramAddr_o,
  output logic                   fetch_req_o,
  input  logic [31:0]            ramData_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  input  logic                   halt_i,
  output logic                   inst_valid_o,
  output logic [31:0]            inst_o,
  output logic [31:0]            inst_pc_o,
  input  logic                   inst_ready_i,
  output logic                   inst_fault_o
);

  state_t       state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  redirect_target;
  logic         bad_redirect;
  logic         fifo_full, fifo_empty;
  logic         fifo_flush, fifo_load;
  logic         pop;
  logic         fetch_req;
  fetch_entry_t fifo_wdata;
  fetch_entry_t head;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign redirect_target = redirect_pc_i;
  assign bad_redirect    = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign inst_fault_o    = head.fault;
`else
  logic unused_align_bits;
  assign unused_align_bits = ^{redirect_pc_i[1:0], head.fault};
  assign redirect_target   = {redirect_pc_i[31:2], 2'b00};
  assign bad_redirect      = 1'b0;
  assign inst_fault_o      = 1'b0;
`endif

  assign pop = inst_valid_o && inst_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bad_redirect) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_BOOT:         state_d = S_RUN;
        S_RUN, S_HALT:  state_d = halt_i ? S_HALT : S_RUN;
        S_FAULT:        state_d = redirect_i ? S_RUN : S_FAULT;
        default:        state_d = S_BOOT;
      endcase
    end
  end

  always_comb begin
    fetch_req  = (state_q == S_RUN) && sram_grant_i && !redirect_i && (!fifo_full || pop);
    fifo_flush = redirect_i;
    fifo_load  = bad_redirect;
    if (bad_redirect) begin
      fifo_wdata.fault = 1'b1;
      fifo_wdata.pc    = redirect_pc_i;
      fifo_wdata.inst  = INST_NOP;
    end else begin
      fifo_wdata.fault = 1'b0;
      fifo_wdata.pc    = fetch_pc_q;
      fifo_wdata.inst  = ramData_i;
    end
  end

  // Redirect beats any fetch in the same cycle; PC arithmetic wraps modulo 2^32.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_target;
    end else if (fetch_req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  inst_fetch_unit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fetch_req),
    .pop_i   (pop),
    .flush_i (fifo_flush),
    .load_i  (fifo_load),
    .wdata_i (fifo_wdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign ramAddr_o    = fetch_pc_q[SRAM_ADDR_W+1:2];
  assign fetch_req_o  = fetch_req;
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = head.inst;
  assign inst_pc_o    = head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit against a queue-based model of the fetch stage.
module tb_inst_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        sram_grant_i;
  logic [19:0] ramAddr_o;
  logic        fetch_req_o;
  logic [31:0] ramData_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        inst_fault_o;

  inst_fetch_unit #(
    .RESET_PC (32'h8000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sram_grant_i  (sram_grant_i),
    .ramAddr_o     (ramAddr_o),
    .fetch_req_o   (fetch_req_o),
    .ramData_i     (ramData_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .inst_fault_o  (inst_fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word content is a tag derived from its address.
  function automatic logic [31:0] sram_word(input logic [19:0] a);
    return {a[11:0] ^ 12'h5A3, a};
  endfunction

  assign ramData_i = sram_word(ramAddr_o);

  typedef struct {
    bit        fault;
    bit [31:0] pc;
    bit [31:0] inst;
  } ent_t;

  ent_t      q[$];
  bit [31:0] m_pc;
  bit        booted;
  bit        stopped;
  bit        faulted;
  int        n_vec;
  int        n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs at the falling edge, advance the model on the rising edge.
  task automatic cycle();
    bit exp_req;
    bit do_pop;
    bit mis;
    @(negedge clk);
    do_pop  = (q.size() > 0) && inst_ready_i;
    exp_req = booted && !faulted && !stopped && sram_grant_i && !redirect_i &&
              ((q.size() < DEPTH) || do_pop);
    check_eq("inst_valid", 64'(inst_valid_o), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check_eq("inst_pc", 64'(inst_pc_o), 64'(q[0].pc));
      check_eq("inst", 64'(inst_o), 64'(q[0].inst));
      check_eq("inst_fault", 64'(inst_fault_o), 64'(q[0].fault));
    end
    check_eq("fetch_req", 64'(fetch_req_o), 64'(exp_req));
    check_eq("ram_addr", 64'(ramAddr_o), 64'(m_pc[21:2]));
    if (do_pop && inst_valid_o) begin
      $display("pop pc=%h inst=%h fault=%0d", inst_pc_o, inst_o, inst_fault_o);
    end
    @(posedge clk);
    mis = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`endif
    if (redirect_i) begin
      q.delete();
      if (mis) q.push_back('{1'b1, redirect_pc_i, 32'h0});
      m_pc = mis ? redirect_pc_i : {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (do_pop) void'(q.pop_front());
      if (exp_req) begin
        q.push_back('{1'b0, m_pc, sram_word(m_pc[21:2])});
        m_pc = m_pc + 32'd4;
      end
    end
    if (mis) begin
      faulted = 1'b1;
      booted  = 1'b1;
    end else if (!booted) begin
      booted  = 1'b1;
      stopped = 1'b0;
    end else if (faulted) begin
      if (redirect_i) begin
        faulted = 1'b0;
        stopped = 1'b0;
      end
    end else begin
      stopped = halt_i;
    end
    #1;
  endtask

  task automatic drive(input bit g, input bit r, input bit h, input bit rd, input bit [31:0] rpc, input int n);
    sram_grant_i  = g;
    inst_ready_i  = r;
    halt_i        = h;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic fill_to(input int target);
    sram_grant_i = 1'b1;
    inst_ready_i = 1'b0;
    halt_i       = 1'b0;
    redirect_i   = 1'b0;
    for (int i = 0; i < 20 && q.size() != target; i++) cycle();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_pc    = 32'h8000_0000;
    booted  = 1'b0;
    stopped = 1'b0;
    faulted = 1'b0;
    rst_n         = 1'b0;
    sram_grant_i  = 1'b1;
    inst_ready_i  = 1'b1;
    halt_i        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;

    #12;
    check_eq("rst_valid", 64'(inst_valid_o), 64'd0);
    check_eq("rst_inst", 64'(inst_o), 64'd0);
    check_eq("rst_pc", 64'(inst_pc_o), 64'd0);
    check_eq("rst_fault", 64'(inst_fault_o), 64'd0);
    check_eq("rst_req", 64'(fetch_req_o), 64'd0);
    check_eq("rst_addr", 64'(ramAddr_o), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming after boot
    drive(1, 1, 0, 0, 32'h0, 10);
    // Decode stall fills the queue, then sustained streaming
    drive(1, 0, 0, 0, 32'h0, 10);
    drive(1, 1, 0, 0, 32'h0, 8);
    // Redirect with three entries queued
    fill_to(3);
    drive(1, 1, 0, 1, 32'h8000_0100, 1);
    drive(1, 1, 0, 0, 32'h0, 6);
    // Grant toggling
    for (int i = 0; i < 12; i++) drive(i[0] == 1'b0, 1, 0, 0, 32'h0, 1);
    // Halt with two entries queued, then resume
    fill_to(2);
    drive(1, 1, 1, 0, 32'h0, 6);
    drive(1, 1, 0, 0, 32'h0, 6);
    // Misaligned redirect, then aligned recovery
    drive(1, 0, 0, 1, 32'h8000_0102, 1);
    drive(1, 0, 0, 0, 32'h0, 4);
    drive(1, 1, 0, 0, 32'h0, 3);
    drive(1, 1, 0, 1, 32'h8000_0200, 1);
    drive(1, 1, 0, 0, 32'h0, 6);
    // Back-to-back redirects: last one wins; also PC wrap past 2^32
    drive(1, 1, 0, 1, 32'h8000_0300, 1);
    drive(1, 1, 0, 1, 32'hFFFF_FFF8, 1);
    drive(1, 1, 0, 0, 32'h0, 6);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bit [31:0] rpc;
      case ($urandom_range(0, 3))
        0:       rpc = $urandom & 32'hFFFF_FFFC;
        1:       rpc = $urandom;
        2:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        default: rpc = 32'h8000_0000 + ($urandom & 32'h0000_0FFC);
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0, rpc, 1);
    end
    drive(1, 1, 0, 1, 32'h8000_0400, 1);
    drive(1, 1, 0, 0, 32'h0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
